fp_div_arbiter: RTL and testbench
=================================

// Module: fp_div_arbiter
// PURPOSE
//  Shares one fp_divider instance between N requesters (e.g. scalar pipe and vector
//  lane). Round-robin arbiter, one operation in flight at a time. The block drives the
//  divider's start/ready_in handshake, routes result+flags back to the requester that
//  owns the operation, and applies a completion watchdog. Sits between issue logic and fp_divider.
// PARAMETERS
//  N_REQ    2     number of requesters (2..8)
//  TIMEOUT  64    max cycles in WAIT before the op is force-completed (>=4)
//  CNT_W    16    width of completed-operation counter
// PORTS
//  clk           in   1        clock, all state on posedge
//  rst_n         in   1        synchronous, active-low reset
//  req_valid     in   N_REQ    requester i has an op pending
//  req_ready     out  N_REQ    one-hot; op of requester i accepted this cycle
//  req_op_a      in   32*N_REQ dividend, slice [32*i+:32]
//  req_op_b      in   32*N_REQ divisor, slice [32*i+:32]
//  req_mode_fp   in   N_REQ    per-requester mode_fp
//  req_round     in   N_REQ    per-requester round_mode
//  rsp_valid     out  N_REQ    one-hot; result for requester i is held on rsp_*
//  rsp_ready     in   N_REQ    requester i takes its result
//  rsp_result    out  32       shared result bus, valid under rsp_valid
//  rsp_flags     out  5        shared exception flags, valid under rsp_valid
//  dv_op_a/dv_op_b out 32      to divider op_a/op_b (registered operands)
//  dv_mode_fp/dv_round out 1   to divider mode_fp/round_mode
//  dv_start      out  1        to divider start
//  dv_ready_out  in   1        divider ready_out (can take start)
//  dv_valid_out  in   1        divider valid_out
//  dv_ready_in   out  1        to divider ready_in (result consumed)
//  dv_result/dv_flags in 32/5  divider result/flags
//  err_timeout   out  1        one-cycle pulse on watchdog expiry
//  ops_done      out  CNT_W    ops returned to requesters, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, all outputs 0, operand/result regs 0,
//   last_grant=N_REQ-1 (requester 0 has first priority), wdog=0, ops_done=0.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE; encoding is free.
//  IDLE: if |req_valid, winner g = first set req_valid scanning last_grant+1 upward
//   with wrap; req_ready[g]=1 combinationally the same cycle; capture op_a/op_b/mode/
//   round of g and owner=g; last_grant<=g; ->ISSUE. No req_ready outside IDLE.
//  ISSUE: dv_start = dv_ready_out (start asserts only while the divider is ready); if
//   dv_start, ->WAIT, wdog<=0. Otherwise stay in ISSUE indefinitely (no watchdog).
//  WAIT: dv_ready_in=1. On dv_valid_out: latch dv_result/dv_flags, ->RESP.
//   Otherwise wdog++; when wdog==TIMEOUT-1 without valid: latch result 32'h7FC00000,
//   flags with `F_INVALID set only, err_timeout=1 for one cycle, ->RESP.
//  RESP: rsp_valid[owner]=1, rsp_result/flags stable; on rsp_ready[owner] ->IDLE,
//   ops_done++. rsp_ready of non-owners ignored. Min issue-to-issue: 4 cycles + unit latency.
//  dv_ready_in=1 also in IDLE and ISSUE: stray/late divider results (e.g. after
//   timeout) are drained and discarded, never routed to a requester.
//  dv_op_*/dv_mode_fp/dv_round are driven from the capture regs in every state.
//  rsp_result/rsp_flags hold last latched values outside RESP (not required 0).
//  Simultaneous: req_valid for the next op while in RESP is not accepted until IDLE;
//   dv_valid_out and watchdog expiry in the same cycle -> real result wins, no err_timeout.
//  Reset mid-op: op is dropped, no response, FSM to IDLE next cycle; requester must reissue.
//  N_REQ=1 degenerates to a pass-through sequencer, same timing.
// TESTING
//  Single req0: 6.0/2.0 (0x40C00000/0x40000000) -> rsp_valid[0], result 0x40400000, flags 0, ops_done=1.
//  req0+req1 valid together from reset -> req0 served first, then req1; with both held, grants alternate 0,1,0,1.
//  dv_ready_out held 0 for 10 cycles in ISSUE -> dv_start stays 0, no err_timeout; issues on ready.
//  Divider never returns valid -> err_timeout pulse TIMEOUT cycles after start, rsp 0x7FC00000, F_INVALID only.
//  rsp_ready[owner] held 0 for 5 cycles -> rsp_* stable, no new req_ready; rsp_ready of other requester ignored.
//  rst_n low during WAIT -> all outputs 0 next cycle; late dv_valid_out drained, no rsp_valid.

Source files
------------

// File: rtl/fp_div_arbiter.sv
// Round-robin front end that shares one fp_divider between N_REQ requesters,
// with a single operation in flight, result routing and a completion watchdog.
module fp_div_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_op_a,
  input  logic [32*N_REQ-1:0]   req_op_b,
  input  logic [N_REQ-1:0]      req_mode_fp,
  input  logic [N_REQ-1:0]      req_round,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_result,
  output logic [4:0]            rsp_flags,
  output logic [31:0]           dv_op_a,
  output logic [31:0]           dv_op_b,
  output logic                  dv_mode_fp,
  output logic                  dv_round,
  output logic                  dv_start,
  input  logic                  dv_ready_out,
  input  logic                  dv_valid_out,
  output logic                  dv_ready_in,
  input  logic [31:0]           dv_result,
  input  logic [4:0]            dv_flags,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      ops_done
);

  localparam int unsigned OW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W      = $clog2(TIMEOUT);
  localparam int unsigned F_INVALID = 4;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     last_q, last_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [31:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic              mode_q, mode_d, round_q, round_d;
  logic [31:0]       res_q, res_d;
  logic [4:0]        flags_q, flags_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0]  ops_q, ops_d;

  logic [N_REQ-1:0]  grant_oh;
  logic [OW-1:0]     grant_idx;
  logic [OW-1:0]     cand;
  logic              found;

  // Scan starts one past the last winner so each requester gets a turn.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = OW'((32'(last_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found           = 1'b1;
        grant_idx       = cand;
        grant_oh[cand]  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    mode_d      = mode_q;
    round_d     = round_q;
    res_d       = res_q;
    flags_d     = flags_q;
    wdog_d      = wdog_q;
    ops_d       = ops_q;
    req_ready   = '0;
    rsp_valid   = '0;
    dv_start    = 1'b0;
    dv_ready_in = 1'b1;
    err_timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready = grant_oh;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
              op_a_d  = req_op_a[32*i +: 32];
              op_b_d  = req_op_b[32*i +: 32];
              mode_d  = req_mode_fp[i];
              round_d = req_round[i];
            end
          end
          owner_d = grant_idx;
          last_d  = grant_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dv_start = dv_ready_out;
        if (dv_ready_out) begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real result in the expiry cycle takes precedence over the watchdog.
        if (dv_valid_out) begin
          res_d   = dv_result;
          flags_d = dv_flags;
          state_d = S_RESP;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          res_d              = QNAN;
          flags_d            = '0;
          flags_d[F_INVALID] = 1'b1;
          err_timeout        = 1'b1;
          state_d            = S_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESP: begin
        dv_ready_in        = 1'b0;
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          ops_d   = ops_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= OW'(N_REQ - 1);
      owner_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      mode_q  <= 1'b0;
      round_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      wdog_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      wdog_q  <= wdog_d;
      ops_q   <= ops_d;
    end
  end

  assign dv_op_a    = op_a_q;
  assign dv_op_b    = op_b_q;
  assign dv_mode_fp = mode_q;
  assign dv_round   = round_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign ops_done   = ops_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter; the divider side is driven by hand.
module tb_fp_div_arbiter;

  localparam int unsigned N       = 2;
  localparam int unsigned TMO     = 8;
  localparam int unsigned CW      = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_mode_fp, req_round;
  logic [32*N-1:0] req_op_a, req_op_b;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic [31:0]     rsp_result, dv_op_a, dv_op_b, dv_result;
  logic [4:0]      rsp_flags, dv_flags;
  logic            dv_mode_fp, dv_round, dv_start, dv_ready_out, dv_valid_out, dv_ready_in;
  logic            err_timeout;
  logic [CW-1:0]   ops_done;

  int checks   = 0;
  int failures = 0;
  int exp_ops  = 0;

  fp_div_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_mode_fp(req_mode_fp), .req_round(req_round),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .dv_op_a(dv_op_a), .dv_op_b(dv_op_b),
    .dv_mode_fp(dv_mode_fp), .dv_round(dv_round),
    .dv_start(dv_start), .dv_ready_out(dv_ready_out),
    .dv_valid_out(dv_valid_out), .dv_ready_in(dv_ready_in),
    .dv_result(dv_result), .dv_flags(dv_flags),
    .err_timeout(err_timeout), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step();
    step();
    rst_n   = 1'b1;
    exp_ops = 0;
  endtask

  // Runs one op from IDLE with whatever req_valid is set; returns the grant seen.
  task automatic serve(input logic [31:0] res, output logic [N-1:0] g);
    dv_ready_out = 1'b1;
    #1;
    g = req_ready;
    step();
    step();
    dv_valid_out = 1'b1; dv_result = res; dv_flags = '0;
    step();
    dv_valid_out = 1'b0;
    rsp_ready = g;
    step();
    rsp_ready = '0;
    exp_ops++;
  endtask

  task automatic test_reset;
    req_valid = '0; req_op_a = '0; req_op_b = '0; req_mode_fp = '0; req_round = '0;
    rsp_ready = '0; dv_ready_out = 1'b0; dv_valid_out = 1'b0; dv_result = '0; dv_flags = '0;
    do_reset();
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (dv_start !== 1'b0) begin failures++; $display("FAIL reset_dv_start got=%b exp=0", dv_start); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    checks++; if (ops_done !== 16'd0) begin failures++; $display("FAIL reset_ops got=%0d exp=0", ops_done); end
    checks++; if (dv_op_a !== 32'd0 || rsp_result !== 32'd0) begin failures++; $display("FAIL reset_regs op_a=%h res=%h exp=0", dv_op_a, rsp_result); end
  endtask

  task automatic test_single;
    req_op_a = {32'h0, 32'h40C0_0000};
    req_op_b = {32'h0, 32'h4000_0000};
    req_mode_fp = 2'b01; req_round = 2'b01;
    req_valid = 2'b01; dv_ready_out = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_req_ready got=%b exp=01", req_ready); end
    step();
    req_valid = '0;
    checks++; if (dv_op_a !== 32'h40C0_0000 || dv_op_b !== 32'h4000_0000 || dv_mode_fp !== 1'b1 || dv_round !== 1'b1)
      begin failures++; $display("FAIL single_operands a=%h b=%h m=%b r=%b exp=40c00000 40000000 1 1", dv_op_a, dv_op_b, dv_mode_fp, dv_round); end
    checks++; if (dv_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", dv_start); end
    step();
    checks++; if (dv_ready_in !== 1'b1 || dv_start !== 1'b0) begin failures++; $display("FAIL single_wait rdy_in=%b start=%b exp=1 0", dv_ready_in, dv_start); end
    dv_valid_out = 1'b1; dv_result = 32'h4040_0000; dv_flags = '0;
    step();
    dv_valid_out = 1'b0;
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h4040_0000 || rsp_flags !== 5'd0)
      begin failures++; $display("FAIL single_rsp v=%b res=%h fl=%b exp=01 40400000 00000", rsp_valid, rsp_result, rsp_flags); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    exp_ops++;
    checks++; if (rsp_valid !== 2'b00 || ops_done !== CW'(exp_ops))
      begin failures++; $display("FAIL single_done v=%b ops=%0d exp=00 %0d", rsp_valid, ops_done, exp_ops); end
  endtask

  task automatic test_arbitration;
    logic [N-1:0] g;
    do_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(32'h3F80_0000, g);
      checks++; if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        begin failures++; $display("FAIL rr_grant idx=%0d got=%b exp=%b", i, g, (i % 2 == 0) ? 2'b01 : 2'b10); end
    end
    req_valid = '0;
    checks++; if (ops_done !== CW'(exp_ops)) begin failures++; $display("FAIL rr_ops got=%0d exp=%0d", ops_done, exp_ops); end
  endtask

  task automatic test_issue_stall;
    req_valid = 2'b01; dv_ready_out = 1'b0;
    #1;
    step();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (dv_start !== 1'b0 || err_timeout !== 1'b0)
        begin failures++; $display("FAIL stall_cycle%0d start=%b err=%b exp=0 0", i, dv_start, err_timeout); end
      step();
    end
    dv_ready_out = 1'b1;
    #1;
    checks++; if (dv_start !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", dv_start); end
    step();
    dv_valid_out = 1'b1; dv_result = 32'h4000_0000; dv_flags = 5'b00001;
    step();
    dv_valid_out = 1'b0;
    checks++; if (rsp_result !== 32'h4000_0000 || rsp_flags !== 5'b00001)
      begin failures++; $display("FAIL stall_rsp res=%h fl=%b exp=40000000 00001", rsp_result, rsp_flags); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    exp_ops++;
  endtask

  task automatic test_timeout(input logic real_at_expiry);
    req_valid = 2'b10; dv_ready_out = 1'b1;
    #1;
    step();
    req_valid = '0;
    checks++; if (dv_start !== 1'b1) begin failures++; $display("FAIL tmo_start got=%b exp=1", dv_start); end
    step();
    for (int c = 1; c < TMO; c++) begin
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_early c=%0d got=%b exp=0", c, err_timeout); end
      step();
    end
    if (real_at_expiry) begin
      dv_valid_out = 1'b1; dv_result = 32'h3F80_0000; dv_flags = '0;
      #1;
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_race_err got=%b exp=0", err_timeout); end
      step();
      dv_valid_out = 1'b0;
      checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h3F80_0000 || rsp_flags !== 5'd0)
        begin failures++; $display("FAIL tmo_race_rsp v=%b res=%h fl=%b exp=10 3f800000 00000", rsp_valid, rsp_result, rsp_flags); end
    end else begin
      checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%b exp=1", err_timeout); end
      step();
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_pulse_len got=%b exp=0", err_timeout); end
      checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h7FC0_0000 || rsp_flags !== 5'b10000)
        begin failures++; $display("FAIL tmo_rsp v=%b res=%h fl=%b exp=10 7fc00000 10000", rsp_valid, rsp_result, rsp_flags); end
    end
    rsp_ready = 2'b10;
    step();
    rsp_ready = '0;
    exp_ops++;
    if (!real_at_expiry) begin
      dv_valid_out = 1'b1; dv_result = 32'h1234_5678;
      #1;
      checks++; if (dv_ready_in !== 1'b1) begin failures++; $display("FAIL tmo_drain_rdy got=%b exp=1", dv_ready_in); end
      step();
      dv_valid_out = 1'b0;
      #1;
      checks++; if (rsp_valid !== 2'b00 || dv_start !== 1'b0 || ops_done !== CW'(exp_ops))
        begin failures++; $display("FAIL tmo_stray v=%b start=%b ops=%0d exp=00 0 %0d", rsp_valid, dv_start, ops_done, exp_ops); end
    end
  endtask

  task automatic test_rsp_hold;
    req_valid = 2'b01; dv_ready_out = 1'b1;
    #1;
    step();
    step();
    dv_valid_out = 1'b1; dv_result = 32'h3EAA_AAAB; dv_flags = 5'b00001;
    step();
    dv_valid_out = 1'b0; dv_result = '0; dv_flags = '0;
    req_valid = 2'b11; rsp_ready = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h3EAA_AAAB || rsp_flags !== 5'b00001 || req_ready !== 2'b00)
        begin failures++; $display("FAIL hold_cycle%0d v=%b res=%h fl=%b rr=%b exp=01 3eaaaaab 00001 00", i, rsp_valid, rsp_result, rsp_flags, req_ready); end
      step();
    end
    rsp_ready = 2'b10;
    step();
    checks++; if (rsp_valid !== 2'b01 || ops_done !== CW'(exp_ops))
      begin failures++; $display("FAIL hold_nonowner v=%b ops=%0d exp=01 %0d", rsp_valid, ops_done, exp_ops); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    exp_ops++;
    #1;
    checks++; if (rsp_valid !== 2'b00 || ops_done !== CW'(exp_ops) || req_ready !== 2'b10)
      begin failures++; $display("FAIL hold_release v=%b ops=%0d rr=%b exp=00 %0d 10", rsp_valid, ops_done, req_ready, exp_ops); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op;
    req_valid = 2'b01; dv_ready_out = 1'b1;
    #1;
    step();
    req_valid = '0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_ops = 0;
    checks++; if (rsp_valid !== 2'b00 || dv_start !== 1'b0 || err_timeout !== 1'b0 || ops_done !== 16'd0 || dv_op_a !== 32'd0 || rsp_result !== 32'd0)
      begin failures++; $display("FAIL midrst_outputs v=%b st=%b err=%b ops=%0d a=%h res=%h exp=all 0", rsp_valid, dv_start, err_timeout, ops_done, dv_op_a, rsp_result); end
    dv_valid_out = 1'b1; dv_result = 32'h4040_0000;
    #1;
    checks++; if (dv_ready_in !== 1'b1) begin failures++; $display("FAIL midrst_drain_rdy got=%b exp=1", dv_ready_in); end
    step();
    dv_valid_out = 1'b0;
    step();
    checks++; if (rsp_valid !== 2'b00 || dv_start !== 1'b0 || rsp_result !== 32'd0)
      begin failures++; $display("FAIL midrst_late v=%b st=%b res=%h exp=00 0 0", rsp_valid, dv_start, rsp_result); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_issue_stall();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_rsp_hold();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
